alu32_cmd_fifo: RTL and testbench



---
 rtl/alu32_cmd_fifo.sv | 109 ++++++++++
 tb/tb_alu32_cmd_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu32_cmd_fifo.sv
// Command FIFO feeding the 32-bit ALU: queues {op, a, b}, pops onto registered operand outputs.
// Optional macro ALU_FIFO_ALMOST_FLAGS_EN adds almost_full / almost_empty outputs.
module alu32_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [2:0]    wr_op,
  input  logic [31:0]   wr_a,
  input  logic [31:0]   wr_b,
  input  logic          rd_en,
  output logic [2:0]    rd_op,
  output logic [31:0]   rd_a,
  output logic [31:0]   rd_b,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [AW:0]   data_count,
`ifdef ALU_FIFO_ALMOST_FLAGS_EN
  output logic          almost_full,
  output logic          almost_empty,
`endif
  output logic [2:0]    fsm_state
);

  localparam int W = 67;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] INIT     = 3'd0;
  localparam logic [2:0] NO_OP    = 3'd1;
  localparam logic [2:0] WRITE    = 3'd2;
  localparam logic [2:0] WR_ERROR = 3'd3;
  localparam logic [2:0] READ     = 3'd4;
  localparam logic [2:0] RD_ERROR = 3'd5;
  localparam logic [2:0] WR_RD    = 3'd6;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          do_wr;
  logic          do_rd;

  assign full      = (data_count == DEPTH_CNT);
  assign empty     = (data_count == '0);
  assign fsm_state = state;

`ifdef ALU_FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (data_count >= DEPTH_CNT - (AW+1)'(1));
  assign almost_empty = (data_count <= (AW+1)'(1));
`endif

  // Requests are single-cycle strobes sampled at the edge; each one is answered
  // by exactly one ack or err pulse in the following cycle, never both.
  // With both requested, a full FIFO still pops and an empty one still pushes.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    state_nxt = NO_OP;
    case ({wr_en, rd_en})
      2'b10:   state_nxt = full  ? WR_ERROR : WRITE;
      2'b01:   state_nxt = empty ? RD_ERROR : READ;
      2'b11:   state_nxt = WR_RD;
      default: state_nxt = NO_OP;
    endcase
  end

  // Storage has no reset; only valid entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[tail] <= {wr_op, wr_a, wr_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      rd_op      <= '0;
      rd_a       <= '0;
      rd_b       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ack <= do_wr;
      wr_err <= wr_en && !do_wr;
      rd_ack <= do_rd;
      rd_err <= rd_en && !do_rd;
      if (do_wr) tail <= tail + AW'(1);
      if (do_rd) begin
        {rd_op, rd_a, rd_b} <= mem[head];
        head                <= head + AW'(1);
      end
      if (do_wr && !do_rd)      data_count <= data_count + (AW+1)'(1);
      else if (do_rd && !do_wr) data_count <= data_count - (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_alu32_cmd_fifo.sv
// Randomized self-checking bench for alu32_cmd_fifo against a queue-based model.
module tb_alu32_cmd_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [2:0]  wr_op = '0;
  logic [31:0] wr_a = '0, wr_b = '0;
  logic [2:0]  rd_op;
  logic [31:0] rd_a, rd_b;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [AW:0] data_count;
  logic [2:0]  fsm_state;
`ifdef ALU_FIFO_ALMOST_FLAGS_EN
  logic        almost_full, almost_empty;
`endif

  alu32_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_a(wr_a), .wr_b(wr_b),
    .rd_en(rd_en), .rd_op(rd_op), .rd_a(rd_a), .rd_b(rd_b), .full(full), .empty(empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
    .data_count(data_count),
`ifdef ALU_FIFO_ALMOST_FLAGS_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: expected queue of stored commands plus last popped command.
  logic [66:0] exp_q[$];
  logic [66:0] exp_rd;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic e_wa, input logic e_we, input logic e_ra, input logic e_re);
    int sz;
    sz = exp_q.size();
    check("rd_data", {rd_op, rd_a, rd_b}, exp_rd);
    check("wr_ack", 67'(wr_ack), 67'(e_wa));
    check("wr_err", 67'(wr_err), 67'(e_we));
    check("rd_ack", 67'(rd_ack), 67'(e_ra));
    check("rd_err", 67'(rd_err), 67'(e_re));
    check("data_count", 67'(data_count), 67'(sz));
    check("full", 67'(full), 67'(sz == DEPTH));
    check("empty", 67'(empty), 67'(sz == 0));
`ifdef ALU_FIFO_ALMOST_FLAGS_EN
    check("almost_full", 67'(almost_full), 67'(sz >= DEPTH - 1));
    check("almost_empty", 67'(almost_empty), 67'(sz <= 1));
`endif
  endtask

  // One clock with the given requests; model is updated from the pre-edge occupancy.
  task automatic cycle(input logic w, input logic r, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    logic ok_w, ok_r;
    wr_en = w; rd_en = r; wr_op = op; wr_a = a; wr_b = b;
    ok_w = w && (exp_q.size() < DEPTH);
    ok_r = r && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (ok_r) exp_rd = exp_q.pop_front();
    if (ok_w) exp_q.push_back({op, a, b});
    check_outputs(ok_w, w && !ok_w, ok_r, r && !ok_r);
  endtask

  task automatic reset_cycle(input logic w, input logic r);
    rst = 1'b1; wr_en = w; rd_en = r;
    wr_op = 3'd5; wr_a = 32'h1234_5678; wr_b = 32'h9abc_def0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_rd = '0;
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input int i);
    cycle(1'b1, 1'b0, 3'(i), 32'(i), ~32'(i));
  endtask

  task automatic pop();
    cycle(1'b0, 1'b1, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    exp_rd = '0;
    reset_cycle(1'b0, 1'b0);
    idle();
    idle();

    // Fill to full, then one rejected push.
    for (int i = 0; i < DEPTH; i++) push(i);
    push(DEPTH);

    // Drain in order, then one rejected pop (outputs hold the last entry).
    for (int i = 0; i <= DEPTH; i++) pop();

    // Simultaneous push/pop at empty, mid, and full occupancy.
    cycle(1'b1, 1'b1, 3'd1, 32'hAAAA_0001, 32'h5555_0001);
    push(10);
    push(11);
    cycle(1'b1, 1'b1, 3'd2, 32'hAAAA_0002, 32'h5555_0002);
    for (int i = 0; i < 5; i++) push(20 + i);
    cycle(1'b1, 1'b1, 3'd3, 32'hAAAA_0003, 32'h5555_0003);

    // Random interleaved traffic across pointer wrap.
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom, $urandom);
    while (exp_q.size() > 0) pop();

    // Reset mid-burst with both requests asserted.
    reset_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push(30 + i);
    reset_cycle(1'b1, 1'b1);
    idle();

    // Occupancy sweep for the status flags.
    for (int i = 0; i < DEPTH; i++) push(40 + i);
    for (int i = 0; i < DEPTH; i++) pop();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
